rvx_core_mdu_sequencer: RTL and testbench
=========================================

RVX_CORE_MDU_SEQUENCER -- requirements
Module: rvx_core_mdu_sequencer

Interface
- REQ-001: Parameter DIV_UNROLL, default 1: number of restoring-division iterations per cycle; legal values are 1, 2 and 4.
- REQ-002: Port clock, input, 1: single clock; all state updates on its rising edge.
- REQ-003: Port reset, input, 1: synchronous, active-high reset.
- REQ-004: Port start_s2, input, 1: a valid M-extension instruction is present in stage 2.
- REQ-005: Port funct3_s2, input, 3: operation select. 0-3 are MUL/MULH/MULHSU/MULHU; 4-7 are DIV/DIVU/REM/REMU.
- REQ-006: Port rs1_data_s2, input, 32: dividend or multiplicand.
- REQ-007: Port rs2_data_s2, input, 32: divisor or multiplier.
- REQ-008: Port flush_s2, input, 1: kills the stage-2 instruction.
- REQ-009: Port stall_s2, output, 1: holds stage 2 and everything upstream of it.
- REQ-010: Port mdu_result_s2, output, 32: result, qualified by mdu_valid_s2.
- REQ-011: Port mdu_valid_s2, output, 1: one-cycle strobe marking a valid result.

Function
- REQ-012: The state machine SHALL have exactly four states: IDLE, MUL, DIV, DONE.
- REQ-013: A start SHALL be accepted only in IDLE, with start_s2=1 and flush_s2=0, at cycle T; operands and funct3 are latched at T.
- REQ-014: stall_s2 SHALL be combinational: (IDLE & start_s2 & ~flush_s2) | MUL | DIV. It SHALL be 0 in DONE.
- REQ-015: Multiply path: IDLE->MUL at T, MUL->DONE at T+1, result valid at T+2.
- REQ-016: Multiply results SHALL be bit-exact to RV32M: MUL gives the low 32 bits of the product; MULH, MULHSU and MULHU give the high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned 64-bit products.
- REQ-017: Division path: IDLE->DIV at T, DIV runs 32/DIV_UNROLL cycles, then DONE; result valid at T+1+32/DIV_UNROLL+1.
- REQ-018: Signed division SHALL operate on magnitudes; quotient is negated when operand signs differ; remainder takes the dividend's sign.
- REQ-019: Divide by zero SHALL complete IDLE->DONE directly, result valid at T+1: quotient 0xFFFFFFFF, remainder rs1.
- REQ-020: Signed overflow (0x80000000 / 0xFFFFFFFF, DIV or REM) SHALL complete IDLE->DONE directly, result valid at T+1: quotient 0x80000000, remainder 0.
- REQ-021: DONE SHALL assert mdu_valid_s2 for exactly one cycle and always return to IDLE; start_s2 seen in DONE SHALL be ignored.
- REQ-022: mdu_result_s2 SHALL hold its last value outside DONE.
- REQ-023: flush_s2=1 in any state SHALL force IDLE next cycle, suppress mdu_valid_s2 in that cycle and the next, and discard the in-flight operation.
- REQ-024: flush_s2 and reset SHALL take priority over start_s2.

Reset
- REQ-025: On reset: state=IDLE, mdu_result_s2=0, mdu_valid_s2=0, stall_s2=0, iteration counter=0, cache valid bit=0.
- REQ-026: Reset asserted mid-operation SHALL abort it, with no mdu_valid_s2 pulse afterwards.

Configuration
- REQ-027: Macro RVX_MDU_DIV_CACHE_EN controls a division result cache.
- REQ-028: With the macro defined, each completed full division SHALL store rs1, rs2, signedness, quotient and remainder, and set the cache valid bit.
- REQ-029: With the macro defined, a later DIV/DIVU/REM/REMU with identical rs1, rs2 and signedness SHALL go IDLE->DONE, result valid at T+1, using the stored value.
- REQ-030: With the macro defined, the cache SHALL be updated only when a division reaches DONE; flushed or reset operations SHALL NOT update it, and reset clears the valid bit.
- REQ-031: Without the macro, every non-special division SHALL take the full latency and no cache storage SHALL be instantiated.

Verification
- REQ-032: MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> mdu_valid_s2 at T+2, result 0xFFFFFFFE; stall_s2 high at T and T+1.
- REQ-033: DIV, rs1=-7 (0xFFFFFFF9), rs2=2, DIV_UNROLL=1 -> valid at T+34, result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
- REQ-034: DIVU, rs1=100, rs2=0 -> valid at T+1, result 0xFFFFFFFF; REM, rs1=0x80000000, rs2=0xFFFFFFFF -> valid at T+1, result 0.
- REQ-035: DIVU, 1000/7; flush_s2 at T+10 -> IDLE at T+11; stall_s2=0 and no mdu_valid_s2 pulse afterwards; a new MUL 3×5 then returns 15.
- REQ-036: With RVX_MDU_DIV_CACHE_EN: DIVU 1000/7 (result 142 at T+34), then REMU 1000/7 -> result 6 valid one cycle after its start; without the macro, the REMU result arrives at the full 34-cycle latency.

Source files
------------

// File: rtl/rvx_core_mdu_sequencer.sv
// ============================================================================
// rvx_core_mdu_sequencer : RV32M multiply/divide sequencer for pipeline stage 2
// Optional division result cache enabled by macro RVX_MDU_DIV_CACHE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvx_core_mdu_sequencer #(
  parameter int DIV_UNROLL = 1  // legal: 1, 2, 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_s2,
  input  logic [2:0]  funct3_s2,
  input  logic [31:0] rs1_data_s2,
  input  logic [31:0] rs2_data_s2,
  input  logic        flush_s2,
  output logic        stall_s2,
  output logic [31:0] mdu_result_s2,
  output logic        mdu_valid_s2
);

  localparam int ITERS = 32 / DIV_UNROLL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_next;

  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [31:0] quo, rem, dvs;
  logic        neg_q, neg_r;
  logic [5:0]  cnt;
  logic [31:0] result;

  logic        accept;
  logic        is_div_in, signed_in, div_zero_in, ovf_in, cache_hit_in, fast_div;
  logic [31:0] fast_result, hit_result;
  logic        div_last;

  assign accept      = (state == IDLE) & start_s2 & ~flush_s2;
  assign is_div_in   = funct3_s2[2];
  assign signed_in   = ~funct3_s2[0];  // DIV/REM are signed, DIVU/REMU are not
  assign div_zero_in = (rs2_data_s2 == 32'h0);
  assign ovf_in      = signed_in & (rs1_data_s2 == 32'h8000_0000) &
                       (rs2_data_s2 == 32'hFFFF_FFFF);
  assign fast_div    = is_div_in & (div_zero_in | ovf_in | cache_hit_in);
  assign div_last    = (cnt == 6'(ITERS));

  always_comb begin
    fast_result = hit_result;
    if (div_zero_in)
      fast_result = funct3_s2[1] ? rs1_data_s2 : 32'hFFFF_FFFF;
    else if (ovf_in)
      fast_result = funct3_s2[1] ? 32'h0 : 32'h8000_0000;
  end

  // Multiply: sign-extend to 64 bits; the low 64 bits of the product are exact.
  logic [63:0] ma, mb, prod;
  logic [31:0] mul_result;
  assign ma   = {{32{opa[31] & ((op == 2'd1) | (op == 2'd2))}}, opa};
  assign mb   = {{32{opb[31] & (op == 2'd1)}}, opb};
  assign prod = ma * mb;
  assign mul_result = (op == 2'd0) ? prod[31:0] : prod[63:32];

  // Restoring division, DIV_UNROLL quotient bits per cycle.
  logic [31:0] quo_n, rem_n;
  logic [32:0] sh;
  always_comb begin
    quo_n = quo;
    rem_n = rem;
    sh    = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      sh    = {rem_n, quo_n[31]};
      quo_n = {quo_n[30:0], 1'b0};
      if (sh >= {1'b0, dvs}) begin
        rem_n    = sh[31:0] - dvs;
        quo_n[0] = 1'b1;
      end else begin
        rem_n = sh[31:0];
      end
    end
  end

  logic [31:0] quo_final, rem_final, div_result;
  assign quo_final  = neg_q ? (32'h0 - quo) : quo;
  assign rem_final  = neg_r ? (32'h0 - rem) : rem;
  assign div_result = op[1] ? rem_final : quo_final;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = !is_div_in ? MUL : (fast_div ? DONE : DIV);
      MUL:  state_next = DONE;
      DIV:  if (div_last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_s2) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (flush_s2) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= funct3_s2[1:0];
          opa   <= rs1_data_s2;
          opb   <= rs2_data_s2;
          cnt   <= '0;
          rem   <= '0;
          quo   <= (signed_in & rs1_data_s2[31]) ? (32'h0 - rs1_data_s2) : rs1_data_s2;
          dvs   <= (signed_in & rs2_data_s2[31]) ? (32'h0 - rs2_data_s2) : rs2_data_s2;
          neg_q <= signed_in & (rs1_data_s2[31] ^ rs2_data_s2[31]);
          neg_r <= signed_in & rs1_data_s2[31];
          if (fast_div) result <= fast_result;
        end
        MUL: result <= mul_result;
        DIV: begin
          if (div_last) begin
            result <= div_result;
          end else begin
            quo <= quo_n;
            rem <= rem_n;
            cnt <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RVX_MDU_DIV_CACHE_EN
  logic        c_valid, c_signed;
  logic [31:0] c_rs1, c_rs2, c_quo, c_rem;

  assign cache_hit_in = c_valid & (c_rs1 == rs1_data_s2) & (c_rs2 == rs2_data_s2) &
                        (c_signed == signed_in);
  assign hit_result   = funct3_s2[1] ? c_rem : c_quo;

  // Only a division that reaches DONE unflushed is remembered.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      c_rs1    <= '0;
      c_rs2    <= '0;
      c_quo    <= '0;
      c_rem    <= '0;
    end else if ((state == DIV) && div_last && !flush_s2) begin
      c_valid  <= 1'b1;
      c_signed <= ~op[0];
      c_rs1    <= opa;
      c_rs2    <= opb;
      c_quo    <= quo_final;
      c_rem    <= rem_final;
    end
  end
`else
  assign cache_hit_in = 1'b0;
  assign hit_result   = 32'h0;
`endif

  assign stall_s2      = accept | (state == MUL) | (state == DIV);
  assign mdu_valid_s2  = (state == DONE) & ~flush_s2;
  assign mdu_result_s2 = result;

endmodule

`default_nettype wire

// File: tb/tb_rvx_core_mdu_sequencer.sv
// Directed self-checking bench for rvx_core_mdu_sequencer (DIV_UNROLL = 1).
`default_nettype none

module tb_rvx_core_mdu_sequencer;

  localparam int DIV_LAT = 34;
`ifdef RVX_MDU_DIV_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = DIV_LAT;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_s2 = 1'b0;
  logic [2:0]  funct3_s2 = 3'd0;
  logic [31:0] rs1_data_s2 = '0;
  logic [31:0] rs2_data_s2 = '0;
  logic        flush_s2 = 1'b0;
  logic        stall_s2;
  logic [31:0] mdu_result_s2;
  logic        mdu_valid_s2;

  int total = 0;
  int bad   = 0;

  rvx_core_mdu_sequencer #(.DIV_UNROLL(1)) dut (
    .clock(clock), .reset(reset), .start_s2(start_s2), .funct3_s2(funct3_s2),
    .rs1_data_s2(rs1_data_s2), .rs2_data_s2(rs2_data_s2), .flush_s2(flush_s2),
    .stall_s2(stall_s2), .mdu_result_s2(mdu_result_s2), .mdu_valid_s2(mdu_valid_s2)
  );

  always #5 clock = ~clock;

  // Issue one op at cycle T and watch 40 cycles; reports first-valid latency.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int pulses,
                        output logic st0, output logic st1);
    @(negedge clock);
    start_s2 = 1'b1; funct3_s2 = f3; rs1_data_s2 = a; rs2_data_s2 = b;
    #1 st0 = stall_s2;
    lat = -1; res = 'x; pulses = 0; st1 = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start_s2 = 1'b0;
        #1 st1 = stall_s2;
      end
      if (mdu_valid_s2) begin
        if (lat < 0) begin lat = k; res = mdu_result_s2; end
        pulses++;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat, pulses; logic [31:0] res; logic st0, st1;
    run_op(f3, a, b, lat, res, pulses, st0, st1);
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    total++;
    if (res !== exp_res) begin bad++; $display("FAIL %s result: got %h want %h", name, res, exp_res); end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL %s pulses: got %0d want 1", name, pulses); end
    total++;
    if (st0 !== 1'b1) begin bad++; $display("FAIL %s stall@T: got %b want 1", name, st0); end
    total++;
    if (st1 !== (exp_lat > 1)) begin bad++; $display("FAIL %s stall@T+1: got %b want %b", name, st1, exp_lat > 1); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (stall_s2 !== 1'b0) begin bad++; $display("FAIL reset stall: got %b want 0", stall_s2); end
    total++;
    if (mdu_valid_s2 !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", mdu_valid_s2); end
    total++;
    if (mdu_result_s2 !== 32'h0) begin bad++; $display("FAIL reset result: got %h want 0", mdu_result_s2); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    check_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    total++;
    if (mdu_result_s2 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL result_hold: got %h want fffffffe", mdu_result_s2); end
    check_op("mul_3x5",   3'd0, 32'd3, 32'd5, 2, 32'd15);
    check_op("mul_low",   3'd0, 32'h1234_5678, 32'h10, 2, 32'h2345_6780);
    check_op("mulh_neg",  3'd1, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF);
    check_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
    check_op("mulhsu_min",3'd2, 32'h8000_0000, 32'h8000_0000, 2, 32'hC000_0000);
    check_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
  endtask

  task automatic test_flush();
    int pulses = 0;
    @(negedge clock);
    start_s2 = 1'b1; funct3_s2 = 3'd5; rs1_data_s2 = 32'd1000; rs2_data_s2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start_s2 = 1'b0;
      if (k == 10) flush_s2 = 1'b1;
    end
    @(negedge clock);
    flush_s2 = 1'b0;
    #1;
    total++;
    if (stall_s2 !== 1'b0) begin bad++; $display("FAIL flush stall@T+11: got %b want 0", stall_s2); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (mdu_valid_s2) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL flush pulses: got %0d want 0", pulses); end
    check_op("mul_after_flush", 3'd0, 32'd3, 32'd5, 2, 32'd15);
  endtask

  task automatic test_div();
    check_op("divu_1000_7", 3'd5, 32'd1000, 32'd7, DIV_LAT, 32'd142);
    check_op("remu_1000_7", 3'd7, 32'd1000, 32'd7, HIT_LAT, 32'd6);
    check_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFD);
    check_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2, HIT_LAT, 32'hFFFF_FFFF);
    check_op("div_7_m2",    3'd4, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'hFFFF_FFFD);
    check_op("rem_7_m2",    3'd6, 32'd7, 32'hFFFF_FFFE, HIT_LAT, 32'd1);
    check_op("divu_max_1",  3'd5, 32'hFFFF_FFFF, 32'd1, DIV_LAT, 32'hFFFF_FFFF);
    check_op("div_min_2",   3'd4, 32'h8000_0000, 32'd2, DIV_LAT, 32'hC000_0000);
    check_op("remu_max_16", 3'd7, 32'hFFFF_FFFF, 32'h10, DIV_LAT, 32'hF);
  endtask

  task automatic test_special();
    check_op("divu_by0", 3'd5, 32'd100, 32'd0, 1, 32'hFFFF_FFFF);
    check_op("remu_by0", 3'd7, 32'd100, 32'd0, 1, 32'd100);
    check_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    check_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
  endtask

  task automatic test_back_to_back();
    int v1 = -1, v2 = -1;
    logic [31:0] r1 = 'x, r2 = 'x;
    @(negedge clock);
    start_s2 = 1'b1; funct3_s2 = 3'd0; rs1_data_s2 = 32'd3; rs2_data_s2 = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) begin rs1_data_s2 = 32'd2; rs2_data_s2 = 32'd2; end
      if (k == 4) start_s2 = 1'b0;
      if (mdu_valid_s2) begin
        if (v1 < 0) begin v1 = k; r1 = mdu_result_s2; end
        else if (v2 < 0) begin v2 = k; r2 = mdu_result_s2; end
      end
    end
    start_s2 = 1'b0;
    total++;
    if (v1 !== 2 || r1 !== 32'd15) begin bad++; $display("FAIL b2b first: got cyc %0d res %h want cyc 2 res f", v1, r1); end
    total++;
    if (v2 !== 5 || r2 !== 32'd4) begin bad++; $display("FAIL b2b second: got cyc %0d res %h want cyc 5 res 4", v2, r2); end
  endtask

  task automatic test_flush_done();
    int pulses = 0;
    @(negedge clock);
    start_s2 = 1'b1; flush_s2 = 1'b1; funct3_s2 = 3'd0; rs1_data_s2 = 32'd9; rs2_data_s2 = 32'd9;
    #1;
    total++;
    if (stall_s2 !== 1'b0) begin bad++; $display("FAIL flush_vs_start stall: got %b want 0", stall_s2); end
    @(negedge clock);
    start_s2 = 1'b0; flush_s2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (mdu_valid_s2) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL flush_vs_start pulses: got %0d want 0", pulses); end
    @(negedge clock);
    start_s2 = 1'b1; rs1_data_s2 = 32'd3; rs2_data_s2 = 32'd5;
    @(negedge clock);
    start_s2 = 1'b0;
    @(negedge clock);
    flush_s2 = 1'b1;
    #1;
    total++;
    if (mdu_valid_s2 !== 1'b0) begin bad++; $display("FAIL flush_in_done valid: got %b want 0", mdu_valid_s2); end
    @(negedge clock);
    flush_s2 = 1'b0;
    #1;
    total++;
    if (mdu_valid_s2 !== 1'b0) begin bad++; $display("FAIL flush_in_done next valid: got %b want 0", mdu_valid_s2); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clock);
    start_s2 = 1'b1; funct3_s2 = 3'd5; rs1_data_s2 = 32'd1000; rs2_data_s2 = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start_s2 = 1'b0;
      if (k == 5) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (stall_s2 !== 1'b0 || mdu_result_s2 !== 32'h0) begin
      bad++; $display("FAIL reset_mid state: stall %b result %h want 0 0", stall_s2, mdu_result_s2);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (mdu_valid_s2) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL reset_mid pulses: got %0d want 0", pulses); end
    check_op("divu_after_reset", 3'd5, 32'd1000, 32'd7, DIV_LAT, 32'd142);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_flush();
    test_div();
    test_special();
    test_back_to_back();
    test_flush_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
